ct_spsram_2048x59_acc_ctrl: RTL

- Initiator-side access controller for the 2048x59 single-port SRAM macro wrapper (active-low CEN/GWEN/WEN, 1-cycle read latency).
- Takes a valid/ready request stream (read, or masked write) and drives the macro pins. Captures Q and returns read data on a valid/ready response stream with a 2-entry buffer.
- Optional post-reset zero sweep. Sits between an L2/tag-array pipeline stage and the memory wrapper.

---
 rtl/ct_spsram_acc_ctrl_pkg.sv | 17 +
 rtl/ct_spsram_2048x59_acc_ctrl_if.sv | 32 +++
 rtl/ct_spsram_acc_ctrl_rsp_buf.sv | 66 ++++++
 rtl/ct_spsram_2048x59_acc_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ct_spsram_acc_ctrl_pkg.sv
// Shared definitions for the 2048x59 single-port SRAM access controller.
//   state_e        : controller state (ST_INIT sweep, ST_RUN traffic)
//   ACC_ADDR_WIDTH : default SRAM address width (depth = 2**ACC_ADDR_WIDTH)
//   ACC_DATA_WIDTH : default data / bit-write-enable width
//   ACC_RSP_DEPTH  : response buffer entries (only 2 is supported)
package ct_spsram_acc_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int unsigned ACC_ADDR_WIDTH = 11;
    localparam int unsigned ACC_DATA_WIDTH = 59;
    localparam int unsigned ACC_RSP_DEPTH  = 2;

endpackage

// File: rtl/ct_spsram_2048x59_acc_ctrl_if.sv
// Request/response bus between the pipeline stage (master) and the SRAM
// access controller (slave).
//   req_vld/req_rdy : request handshake, req_wr selects write (1) or read (0)
//   req_addr        : SRAM address
//   req_wdata       : write data
//   req_wmask       : active-high per-bit write enable
//   rsp_vld/rsp_rdy : read response handshake
//   rsp_rdata       : read data, returned strictly in request order
interface ct_spsram_2048x59_acc_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = ct_spsram_acc_ctrl_pkg::ACC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ct_spsram_acc_ctrl_pkg::ACC_DATA_WIDTH
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/ct_spsram_acc_ctrl_rsp_buf.sv
// Two-entry in-order response FIFO with bypass.
//   clk, rst : clock, asynchronous active-high reset
//   push     : din carries fresh SRAM read data this cycle
//   din      : SRAM Q
//   pop_rdy  : consumer ready
//   vld/dout : response valid and data (din bypasses when empty)
//   count    : stored entries, used by the controller for credits
module ct_spsram_acc_ctrl_rsp_buf #(
    parameter int unsigned DATA_WIDTH = ct_spsram_acc_ctrl_pkg::ACC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop_rdy,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign vld  = (count != 2'd0) | push;
    assign dout = (count == 2'd0) ? din : head;
    assign pop  = vld & pop_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    // bypassed data is stored only when not consumed
                    if (push && !pop) begin
                        head  <= din;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail  <= din;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

    // credit accounting upstream keeps a full buffer from ever seeing a push
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == 2'd2));

endmodule

// File: rtl/ct_spsram_2048x59_acc_ctrl.sv
// Initiator-side access controller for the 2048x59 single-port SRAM macro
// (active-low CEN/GWEN/WEN, 1-cycle read latency).
//   CLK, RST  : clock (shared with the macro), asynchronous active-high reset
//   bus       : request/response stream (slave modport)
//   init_done : controller accepting traffic
//   A/CEN/GWEN/WEN/D : macro pins, combinational from the accepted request
//   Q         : macro read data, valid the cycle after a read access
// Optional build macro CT_SPSRAM_ACC_CTRL_INIT_EN: after reset, write zero to
// every address (one per cycle) before accepting traffic.
module ct_spsram_2048x59_acc_ctrl #(
    parameter int unsigned ADDR_WIDTH = ct_spsram_acc_ctrl_pkg::ACC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ct_spsram_acc_ctrl_pkg::ACC_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = ct_spsram_acc_ctrl_pkg::ACC_RSP_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    ct_spsram_2048x59_acc_ctrl_if.slave  bus,
    output logic                         init_done,
    output logic [ADDR_WIDTH-1:0]        A,
    output logic                         CEN,
    output logic                         GWEN,
    output logic [DATA_WIDTH-1:0]        WEN,
    output logic [DATA_WIDTH-1:0]        D,
    input  logic [DATA_WIDTH-1:0]        Q
);
    import ct_spsram_acc_ctrl_pkg::*;

`ifdef CT_SPSRAM_ACC_CTRL_INIT_EN
    localparam state_e RESET_STATE   = ST_INIT;
    localparam logic   INIT_DONE_RST = 1'b0;
`else
    localparam state_e RESET_STATE   = ST_RUN;
    localparam logic   INIT_DONE_RST = 1'b1;
`endif

    state_e                state;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  req_rdy_q;
    logic                  init_done_q;
    logic                  rd_inflight;
    logic [1:0]            buf_count;
    logic                  accept;
    logic                  accept_rd;
    logic                  pop;
    logic [2:0]            outstanding;
    logic [2:0]            outstanding_next;

    assign accept    = bus.req_vld & req_rdy_q;
    assign accept_rd = accept & ~bus.req_wr;
    assign pop       = bus.rsp_vld & bus.rsp_rdy;

    // a read stays outstanding from accept through its Q cycle until popped
    assign outstanding      = {1'b0, buf_count} + {2'b00, rd_inflight};
    assign outstanding_next = outstanding + {2'b00, accept_rd} - {2'b00, pop};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= RESET_STATE;
            sweep_addr  <= '0;
            req_rdy_q   <= 1'b0;
            init_done_q <= INIT_DONE_RST;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= accept_rd;
            case (state)
                ST_INIT: begin
                    sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                    if (&sweep_addr) begin
                        state       <= ST_RUN;
                        req_rdy_q   <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    req_rdy_q   <= (outstanding_next < 3'(RSP_DEPTH));
                    init_done_q <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.req_rdy = req_rdy_q;
    assign init_done   = init_done_q;

    always_comb begin
        A    = '0;
        D    = '0;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        // RST gating deselects the macro while reset holds the state in INIT
        if (state == ST_INIT && !RST) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = sweep_addr;
        end else if (accept_rd) begin
            CEN = 1'b0;
            A   = bus.req_addr;
        end else if (accept && (bus.req_wmask != '0)) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = ~bus.req_wmask;
            A    = bus.req_addr;
            D    = bus.req_wdata;
        end
    end

    ct_spsram_acc_ctrl_rsp_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_buf (
        .clk     (CLK),
        .rst     (RST),
        .push    (rd_inflight),
        .din     (Q),
        .pop_rdy (bus.rsp_rdy),
        .vld     (bus.rsp_vld),
        .dout    (bus.rsp_rdata),
        .count   (buf_count)
    );

endmodule
